// File: rtl/f_multiplier_seq.sv
// Sequential IEEE-754 single multiplier: shift-add mantissa, RNE rounding.
// Ports: clk, RST (async low), EN start, A/B operands, result + flags, busy, done.
module f_multiplier_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   exception,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(SW);

  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX   = XW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]        CLAST  = CW'(SW - 1);

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MUL, S_NORM, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]         a_q, b_q;
  logic                 sign_q;
  logic signed [XW-1:0] exp_q;
  logic [CW-1:0]        cnt_q;
  logic [PW-1:0]        mcand_q;
  logic [SW-1:0]        mplier_q;
  logic [PW-1:0]        acc_q;
  logic [W-1:0]         pres_q;
  logic                 pov_q, pun_q, pex_q;
  logic [W-1:0]         result_q;
  logic                 ovf_q, unf_q, exc_q;
  logic                 busy_q, done_q;

  // Operand classification (denormals count as zero)
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic is_nan, is_inf, is_zero, special;
  logic sgn;

  always_comb begin
    ea      = a_q[W-2:MAN_W];
    eb      = b_q[W-2:MAN_W];
    ma      = a_q[MAN_W-1:0];
    mb      = b_q[MAN_W-1:0];
    sgn     = a_q[W-1] ^ b_q[W-1];
    a_nan   = (&ea) && (|ma);
    b_nan   = (&eb) && (|mb);
    a_inf   = (&ea) && !(|ma);
    b_inf   = (&eb) && !(|mb);
    a_zero  = (ea == '0);
    b_zero  = (eb == '0);
    is_nan  = a_nan || b_nan
           || (a_inf && b_zero) || (b_inf && a_zero);
    is_inf  = a_inf || b_inf;
    is_zero = a_zero || b_zero;
    special = is_nan || is_inf || is_zero;
  end

  // Normalise and round the finished product
  logic [MAN_W-1:0]     man_t;
  logic                 grd, stk, rnd;
  logic [MAN_W:0]       man_r;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]     man_f;
  logic                 n_ovf, n_unf;

  always_comb begin
    if (acc_q[PW-1]) begin
      man_t = acc_q[PW-2 -: MAN_W];
      grd   = acc_q[PW-2-MAN_W];
      stk   = |acc_q[PW-3-MAN_W:0];
      exp_n = exp_q + XW'(1);
    end else begin
      man_t = acc_q[PW-3 -: MAN_W];
      grd   = acc_q[PW-3-MAN_W];
      stk   = |acc_q[PW-4-MAN_W:0];
      exp_n = exp_q;
    end
    rnd   = grd && (stk || man_t[0]);
    man_r = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd};
    man_f = man_r[MAN_W-1:0];
    exp_r = exp_n;
    if (man_r[MAN_W]) begin
      man_f = '0;
      exp_r = exp_n + XW'(1);
    end
    n_ovf = (exp_r >= EMAX);
    n_unf = (exp_r <= 0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (EN) state_d = S_CHECK;
      S_CHECK: state_d = special ? S_DONE : S_MUL;
      S_MUL:   if (cnt_q == CLAST) state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      pres_q   <= '0;
      pov_q    <= 1'b0;
      pun_q    <= 1'b0;
      pex_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (EN) begin
            a_q    <= A;
            b_q    <= B;
            busy_q <= 1'b1;
          end
        end
        S_CHECK: begin
          pov_q    <= 1'b0;
          pun_q    <= 1'b0;
          pex_q    <= 1'b0;
          sign_q   <= sgn;
          exp_q    <= $signed({2'b00, ea})
                    + $signed({2'b00, eb}) - BIAS_X;
          cnt_q    <= '0;
          acc_q    <= '0;
          mcand_q  <= {{SW{1'b0}}, 1'b1, ma};
          mplier_q <= {1'b1, mb};
          if (is_nan) begin
            pres_q <= QNAN;
            pex_q  <= 1'b1;
          end else if (is_inf) begin
            pres_q <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else begin
            pres_q <= {sgn, {(W-1){1'b0}}};
          end
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_NORM: begin
          exp_q <= exp_r;
          if (n_ovf) begin
            pres_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pov_q  <= 1'b1;
          end else if (n_unf) begin
            pres_q <= {sign_q, {(W-1){1'b0}}};
            pun_q  <= 1'b1;
          end else begin
            pres_q <= {sign_q, exp_r[EXP_W-1:0], man_f};
          end
        end
        S_DONE: begin
          result_q <= pres_q;
          ovf_q    <= pov_q;
          unf_q    <= pun_q;
          exc_q    <= pex_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_f_multiplier_seq.sv
// Directed bench for f_multiplier_seq: products, specials, range,
// handshake, back-to-back and mid-operation reset.
module tb_f_multiplier_seq;

  logic        clk = 1'b0;
  logic        RST;
  logic        EN;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        overflow, underflow, exception, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  f_multiplier_seq dut (
    .clk(clk), .RST(RST), .EN(EN), .A(A), .B(B),
    .result(result), .overflow(overflow),
    .underflow(underflow), .exception(exception),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    A = a; B = b; EN = 1'b1;
    @(posedge clk);
    #1;
    EN = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] er,
                          input logic [2:0]  ef,
                          input int          elat);
    int lat;
    run_op(a, b, lat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"},
        {29'd0, overflow, underflow, exception},
        {29'd0, ef});
    chk({tag, "_lat"}, lat, elat);
  endtask

  initial begin
    int nd;
    int lat, lat2;
    RST = 1'b0; EN = 1'b0; A = '0; B = '0;
    #12;
    chk("rst_res", result, 32'h0);
    chk("rst_flg", {29'd0, overflow, underflow, exception}, 32'h0);
    chk("rst_bsy", {30'd0, busy, done}, 32'h0);
    @(negedge clk);
    RST = 1'b1;

    // flags field order: {overflow, underflow, exception}
    check_op("n9x4",  32'h411C0000, 32'h40800000, 32'h421C0000, 3'b000, 27);
    check_op("n22xh", 32'h41B26666, 32'hBF000000, 32'hC1326666, 3'b000, 27);
    check_op("n15sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27);
    check_op("rdn",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 27);
    check_op("rlsb",  32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 27);
    check_op("infx0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 2);
    check_op("infxn", 32'h7F800000, 32'hC11C0000, 32'hFF800000, 3'b000, 2);
    check_op("zxn",   32'h00000000, 32'h411C0000, 32'h00000000, 3'b000, 2);
    check_op("nan",   32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b001, 2);
    check_op("ovf",   32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 27);
    check_op("unf",   32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 27);
    check_op("nzneg", 32'h80000000, 32'h411C0000, 32'h80000000, 3'b000, 2);

    // EN pulse while busy must be ignored
    @(negedge clk);
    A = 32'h411C0000; B = 32'h40800000; EN = 1'b1;
    @(posedge clk);
    #1;
    EN = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    A = 32'h3FC00000; B = 32'h3FC00000; EN = 1'b1;
    @(posedge clk);
    #1;
    EN = 1'b0;
    chk("hs_busy", {31'd0, busy}, 32'd1);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("hs_ndone", nd, 1);
    chk("hs_res", result, 32'h421C0000);

    // EN held high: second op starts right after DONE
    @(negedge clk);
    A = 32'h3FC00000; B = 32'h3FC00000; EN = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h411C0000; B = 32'h40800000;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_lat1", lat, 27);
    chk("b2b_res1", result, 32'h40100000);
    lat2 = 0;
    do begin
      @(posedge clk);
      #1;
      lat2++;
    end while (!done && lat2 < 80);
    EN = 1'b0;
    chk("b2b_lat2", lat2, 28);
    chk("b2b_res2", result, 32'h421C0000);

    // asynchronous reset in the middle of MUL
    @(negedge clk);
    A = 32'h41B26666; B = 32'hBF000000; EN = 1'b1;
    @(posedge clk);
    #1;
    EN = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    RST = 1'b0;
    #1;
    chk("mr_res", result, 32'h0);
    chk("mr_bsy", {30'd0, busy, done}, 32'h0);
    @(negedge clk);
    RST = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("mr_ndone", nd, 0);
    check_op("mr_new", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
